// File: rtl/trap_csr_unit.sv
// trap_csr_unit: M-mode trap/CSR unit at the MEM commit point with a registered redirect and flush.
module trap_csr_unit #(
    parameter int XLEN = 32,
    parameter int NUM_IRQ = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            exc_valid,
    input  logic [4:0]      exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            trap_taken,
    output logic            mie_global
);
    typedef enum logic {RUN, REDIRECT} state_t;
    state_t state, state_next;
    logic [NUM_IRQ-1:0] irq_s1, irq_s2, mie_bits, pend;
    logic mstatus_mie, mstatus_mpie, csr_hit;
    logic [XLEN-1:0] mtvec, mepc, mcause, mtval, csr_nv, target;
    logic [4:0] irq_code;
    logic accept, irq_pend, take_exc, take_irq, take_trap, take_mret, do_csr;

    always_comb begin
        csr_rdata = '0;
        csr_hit = 1'b1;
        case (csr_addr)
            12'h300: begin
                csr_rdata[3] = mstatus_mie;
                csr_rdata[7] = mstatus_mpie;
            end
            12'h304: csr_rdata[16 +: NUM_IRQ] = mie_bits;
            12'h305: csr_rdata = mtvec;
            12'h341: csr_rdata = mepc;
            12'h342: csr_rdata = mcause;
            12'h343: csr_rdata = mtval;
            12'h344: csr_rdata[16 +: NUM_IRQ] = irq_s2;
            default: csr_hit = 1'b0;
        endcase
    end

    assign csr_illegal = csr_en && !csr_hit;
    assign csr_nv = (csr_op == 2'b01) ? csr_wdata : (csr_op == 2'b10) ? (csr_rdata | csr_wdata) : (csr_rdata & ~csr_wdata);
    assign pend = irq_s2 & mie_bits;
    assign irq_pend = mstatus_mie && (|pend);

    // Lowest-numbered pending line wins.
    always_comb begin
        irq_code = 5'd16;
        for (int k = NUM_IRQ - 1; k >= 0; k--)
            if (pend[k]) irq_code = 5'(16 + k);
    end

    assign accept = (state == RUN) && commit_valid;
    assign take_exc = accept && exc_valid;
    assign take_irq = accept && !exc_valid && irq_pend;
    assign take_trap = take_exc || take_irq;
    assign take_mret = accept && !take_trap && mret;
    assign do_csr = accept && !take_trap && !mret && csr_en && csr_hit && (csr_op == 2'b01 || (csr_op[1] && |csr_wdata));
    assign target = take_mret ? mepc : {mtvec[XLEN-1:2], 2'b00} + ((take_irq && mtvec[0]) ? XLEN'({irq_code, 2'b00}) : '0);

    always_comb begin
        state_next = (take_trap || take_mret) ? REDIRECT : RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            redirect_pc <= '0;
            trap_taken <= 1'b0;
        end else begin
            state <= state_next;
            redirect_pc <= (take_trap || take_mret) ? target : '0;
            trap_taken <= take_trap;
        end
    end

    assign redirect = state == REDIRECT;
    assign flush = redirect;
    assign mie_global = mstatus_mie;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
            mstatus_mie <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_bits <= '0;
            mtvec <= {MTVEC_RESET[XLEN-1:2], 1'b0, VECTORED_EN && MTVEC_RESET[0]};
            mepc <= '0;
            mcause <= '0;
            mtval <= '0;
        end else begin
            irq_s1 <= irq_in;
            irq_s2 <= irq_s1;
            if (take_trap) begin
                mepc <= commit_pc & ~XLEN'(3);
                mstatus_mpie <= mstatus_mie;
                mstatus_mie <= 1'b0;
                mcause <= take_exc ? {{(XLEN-5){1'b0}}, exc_cause} : {1'b1, {(XLEN-6){1'b0}}, irq_code};
                mtval <= take_exc ? exc_tval : '0;
            end else if (take_mret) begin
                mstatus_mie <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (do_csr) begin
                case (csr_addr)
                    12'h300: begin
                        mstatus_mie <= csr_nv[3];
                        mstatus_mpie <= csr_nv[7];
                    end
                    12'h304: mie_bits <= csr_nv[16 +: NUM_IRQ];
                    12'h305: mtvec <= {csr_nv[XLEN-1:2], 1'b0, VECTORED_EN && csr_nv[0]};
                    12'h341: mepc <= csr_nv & ~XLEN'(3);
                    12'h342: mcause <= csr_nv;
                    12'h343: mtval <= csr_nv;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trap_csr_unit.sv
// tb_trap_csr_unit: directed plan plus random commits checked against a CSR-level reference model.
module tb_trap_csr_unit;
    logic clk = 1'b0, reset = 1'b0;
    logic [3:0] irq_in = '0;
    logic commit_valid = 1'b0, exc_valid = 1'b0, mret = 1'b0, csr_en = 1'b0;
    logic [31:0] commit_pc = '0, exc_tval = '0, csr_wdata = '0;
    logic [4:0] exc_cause = '0;
    logic [1:0] csr_op = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_rdata, redirect_pc;
    logic csr_illegal, redirect, flush, trap_taken, mie_global;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    trap_csr_unit dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .mret(mret), .csr_en(csr_en),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .trap_taken(trap_taken), .mie_global(mie_global)
    );

    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, e_pc;
    logic [3:0] m_hist[$];
    bit m_redir, e_red, e_trap;
    logic [11:0] addrs[9] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0, 12'h301};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // mip shows the irq level sampled two clock edges ago.
    function automatic logic [31:0] m_mip();
        return (m_hist.size() == 2) ? {12'b0, m_hist[0], 16'b0} : 32'b0;
    endfunction

    function automatic bit m_legal(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip();
            default: return 32'b0;
        endcase
    endfunction

    task automatic m_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_hist.delete();
        m_redir = 0;
    endtask

    task automatic tick();
        logic [31:0] pend, old, nv;
        int c;
        #1;
        chk("csr_rdata", csr_rdata, m_read(csr_addr));
        chk("csr_illegal", csr_illegal, csr_en && !m_legal(csr_addr));
        e_red = 0; e_trap = 0; e_pc = 0;
        pend = m_mip() & m_mie;
        if (!m_redir && commit_valid) begin
            if (exc_valid || (m_mstatus[3] && pend != 0)) begin
                e_red = 1; e_trap = 1;
                c = 16;
                while (!exc_valid && !pend[c]) c++;
                e_pc = (m_mtvec & ~32'h3) + ((!exc_valid && m_mtvec[0]) ? 4 * c : 0);
                m_mepc = commit_pc & ~32'h3;
                m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
                m_mcause = exc_valid ? {27'b0, exc_cause} : (32'h8000_0000 | c);
                m_mtval = exc_valid ? exc_tval : 32'h0;
            end else if (mret) begin
                e_red = 1;
                e_pc = m_mepc;
                m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            end else if (csr_en && m_legal(csr_addr) && csr_op != 0 && !(csr_op != 1 && csr_wdata == 0)) begin
                old = m_read(csr_addr);
                nv = (csr_op == 1) ? csr_wdata : (csr_op == 2) ? (old | csr_wdata) : (old & ~csr_wdata);
                case (csr_addr)
                    12'h300: m_mstatus = nv & 32'h88;
                    12'h304: m_mie = nv & 32'h000F_0000;
                    12'h305: m_mtvec = nv & ~32'h2;
                    12'h341: m_mepc = nv & ~32'h3;
                    12'h342: m_mcause = nv;
                    12'h343: m_mtval = nv;
                    default: ;
                endcase
            end
        end
        m_redir = e_red;
        m_hist.push_back(irq_in);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
        @(posedge clk); #1;
        chk("redirect", redirect, e_red);
        chk("flush", flush, e_red);
        chk("trap_taken", trap_taken, e_trap);
        chk("mie_global", mie_global, m_mstatus[3]);
        if (e_red) chk("redirect_pc", redirect_pc, e_pc);
        @(negedge clk);
        commit_valid = 0; exc_valid = 0; mret = 0; csr_en = 0; csr_op = 0;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        commit_valid = 1; csr_en = 1; csr_op = op; csr_addr = a; csr_wdata = d;
        tick();
    endtask

    task automatic expect_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic commit_exc(input logic [31:0] pc, input logic [4:0] cause);
        commit_valid = 1; exc_valid = 1; commit_pc = pc; exc_cause = cause; exc_tval = pc ^ 32'h5A5A_0000;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_redirect", redirect, 0);
        chk("rst_flush", flush, 0);
        chk("rst_trap", trap_taken, 0);
        chk("rst_pc", redirect_pc, 0);
        chk("rst_mie", mie_global, 0);
        expect_rd("rst_mtvec", 12'h305, 32'h100);
        m_reset();
        @(negedge clk);
        reset = 1;
        csr(2'b01, 12'h305, 32'h200);
        csr(2'b10, 12'h304, 32'h1_0000);
        expect_rd("tp_mie", 12'h304, 32'h1_0000);
        tick();
        commit_valid = 1; csr_en = 1; csr_op = 2'b00; csr_addr = 12'h7C0;
        #1;
        chk("tp_illegal", csr_illegal, 1);
        tick();
        csr(2'b01, 12'h7C0, 32'hFFFF_FFFF);
        expect_rd("tp_mtvec_kept", 12'h305, 32'h200);
        commit_exc(32'h40, 5'd11);
        chk("tp_exc_pc", redirect_pc, 32'h200);
        chk("tp_exc_trap", trap_taken, 1);
        expect_rd("tp_mepc", 12'h341, 32'h40);
        expect_rd("tp_mcause", 12'h342, 32'd11);
        tick();
        csr(2'b01, 12'h305, 32'h201);
        csr(2'b10, 12'h300, 32'h8);
        csr(2'b10, 12'h304, 32'h6_0000);
        irq_in = 4'b0110;
        tick();
        tick();
        commit_valid = 1; commit_pc = 32'h80;
        tick();
        chk("tp_vec_pc", redirect_pc, 32'h244);
        expect_rd("tp_vec_cause", 12'h342, 32'h8000_0011);
        irq_in = 4'b0000;
        tick();
        commit_valid = 1; mret = 1; commit_pc = 32'h250;
        tick();
        chk("tp_mret_pc", redirect_pc, 32'h80);
        chk("tp_mret_trap", trap_taken, 0);
        expect_rd("tp_mret_mstatus", 12'h300, 32'h88);
        tick();
        irq_in = 4'b0001;
        tick();
        tick();
        commit_exc(32'h90, 5'd2);
        expect_rd("tp_prio_cause", 12'h342, 32'd2);
        commit_exc(32'hA0, 5'd3);
        chk("tp_wrongpath", redirect, 0);
        irq_in = 4'b0000;
        tick();
        commit_exc(32'hB0, 5'd11);
        chk("tp_pre_rst_red", redirect, 1);
        reset = 0;
        csr_addr = 12'h305;
        #1;
        chk("tp_rst_red", redirect, 0);
        chk("tp_rst_flush", flush, 0);
        chk("tp_rst_mtvec", csr_rdata, 32'h100);
        m_reset();
        @(negedge clk);
        reset = 1;
        commit_exc(32'h300, 5'd3);
        chk("tp_post_rst_pc", redirect_pc, 32'h100);
        tick();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) irq_in = 4'($urandom);
            commit_valid = $urandom_range(0, 9) < 7;
            commit_pc = $urandom;
            exc_valid = $urandom_range(0, 9) == 0;
            exc_cause = 5'($urandom);
            exc_tval = $urandom;
            mret = $urandom_range(0, 9) == 0;
            csr_en = $urandom_range(0, 9) < 5;
            csr_op = 2'($urandom);
            csr_addr = addrs[$urandom_range(0, 8)];
            csr_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
